// File: rtl/key_enc_pkg.sv
// key_enc_pkg: shared types, sizes and helper functions for the 8-key priority encoder.
//   - state_t     : encoder FSM states (IDLE, HELD)
//   - CODE_W/KEY_N: code width and key count
//   - prio_enc8   : active-high key vector -> 3-bit code (highest index wins, code = 7 - index)
//   - popcnt_gt1  : true when more than one bit of the vector is set
package key_enc_pkg;

    localparam int CODE_W = 3;
    localparam int KEY_N  = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HELD = 1'b1
    } state_t;

    // Ascending scan so the highest set index is the last one written and therefore wins.
    function automatic logic [CODE_W-1:0] prio_enc8(input logic [KEY_N-1:0] act);
        logic [CODE_W-1:0] c;
        c = 3'd0;
        for (int i = 0; i < KEY_N; i++) begin
            if (act[i]) begin
                c = 3'd7 - 3'(i);
            end
        end
        return c;
    endfunction

    function automatic logic popcnt_gt1(input logic [KEY_N-1:0] act);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < KEY_N; i++) begin
            n = n + {3'd0, act[i]};
        end
        return (n > 4'd1);
    endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce: two-flop synchroniser, sample tick generator and per-key debounce filter.
// Ports:
//   i_clk, i_rst  : clock, asynchronous active-high reset
//   i_key_n[7:0]  : raw active-low buttons (asynchronous)
//   o_db[7:0]     : debounced keys, active-low (FF = all released)
//   o_tick        : one-cycle pulse every DEBOUNCE_CYCLES clocks
import key_enc_pkg::*;

module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 240000
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [KEY_N-1:0] i_key_n,
    output logic [KEY_N-1:0] o_db,
    output logic             o_tick
);

    localparam int                CNT_W   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

    logic [KEY_N-1:0] r_sync1;
    logic [KEY_N-1:0] r_sync2;
    logic [KEY_N-1:0] r_samp;
    logic [KEY_N-1:0] r_db;
    logic [CNT_W-1:0] r_cnt;
    logic             w_tick;
    logic [KEY_N-1:0] w_diff;

    assign w_tick = (r_cnt == CNT_MAX);
    // A bit that differs from the previous sample is still bouncing; keep its old db value.
    assign w_diff = r_sync2 ^ r_samp;

    // Synchroniser, tick counter and two-sample agreement filter.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= 8'hFF;
            r_sync2 <= 8'hFF;
            r_samp  <= 8'hFF;
            r_db    <= 8'hFF;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_key_n;
            r_sync2 <= r_sync1;
            if (w_tick) begin
                r_cnt  <= '0;
                r_samp <= r_sync2;
                r_db   <= (r_sync2 & ~w_diff) | (r_db & w_diff);
            end else begin
                r_cnt  <= r_cnt + CNT_ONE;
            end
        end
    end

    assign o_db   = r_db;
    assign o_tick = w_tick;

endmodule

// File: rtl/key_encoder83.sv
// key_encoder83: debounced 8-key to 3-bit priority encoder with press/release events.
// Code = 7 - index of the highest pressed key (inverse of the board's 3-8 LED decoder).
// Optional auto-repeat: define KEY_ENC_REPEAT_EN to re-pulse o_press every REPEAT_TICKS
// sample ticks while the same code is held.
// Ports:
//   i_clk, i_rst  : clock, asynchronous active-high reset
//   i_key_n[7:0]  : raw active-low buttons
//   o_code[2:0]   : registered code of the highest pressed key (holds after release)
//   o_valid       : at least one debounced key pressed
//   o_press       : one-cycle pulse on new key or code change (and on repeat, if enabled)
//   o_release     : one-cycle pulse when the last key is released
//   o_multi       : more than one debounced key pressed
import key_enc_pkg::*;

module key_encoder83 #(
    parameter int DEBOUNCE_CYCLES = 240000
`ifdef KEY_ENC_REPEAT_EN
    , parameter int REPEAT_TICKS  = 25
`endif
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [KEY_N-1:0]  i_key_n,
    output logic [CODE_W-1:0] o_code,
    output logic              o_valid,
    output logic              o_press,
    output logic              o_release,
    output logic              o_multi
);

    logic [KEY_N-1:0]  w_db;
    logic              w_tick;
    logic [KEY_N-1:0]  w_act;
    logic              w_any;
    logic [CODE_W-1:0] w_enc;
    logic              w_multiple;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CODE_W-1:0] r_code;
    logic [CODE_W-1:0] w_code_nxt;
    logic              r_valid;
    logic              w_valid_nxt;
    logic              r_press;
    logic              w_press_nxt;
    logic              r_release;
    logic              w_release_nxt;
    logic              r_multi;

`ifdef KEY_ENC_REPEAT_EN
    localparam int               RPT_W    = $clog2(REPEAT_TICKS + 1);
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_TICKS - 1);
    localparam logic [RPT_W-1:0] RPT_ONE  = RPT_W'(1);
    logic [RPT_W-1:0] r_rpt;
    logic [RPT_W-1:0] w_rpt_nxt;
`endif

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_deb (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_key_n (i_key_n),
        .o_db    (w_db),
        .o_tick  (w_tick)
    );

    assign w_act      = ~w_db;
    assign w_any      = |w_act;
    assign w_enc      = prio_enc8(w_act);
    assign w_multiple = popcnt_gt1(w_act);

    // Next-state and next-output logic; outputs are registered in the block below.
    always_comb begin
        w_state_nxt   = r_state;
        w_code_nxt    = r_code;
        w_valid_nxt   = r_valid;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
`ifdef KEY_ENC_REPEAT_EN
        w_rpt_nxt     = r_rpt;
`endif
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt = HELD;
                    w_code_nxt  = w_enc;
                    w_valid_nxt = 1'b1;
                    w_press_nxt = 1'b1;
`ifdef KEY_ENC_REPEAT_EN
                    w_rpt_nxt   = '0;
`endif
                end else begin
                    w_valid_nxt = 1'b0;
                end
            end
            HELD: begin
                if (!w_any) begin
                    // Code intentionally holds its last value after release.
                    w_state_nxt   = IDLE;
                    w_valid_nxt   = 1'b0;
                    w_release_nxt = 1'b1;
                end else if (w_enc != r_code) begin
                    w_code_nxt  = w_enc;
                    w_valid_nxt = 1'b1;
                    w_press_nxt = 1'b1;
`ifdef KEY_ENC_REPEAT_EN
                    w_rpt_nxt   = '0;
`endif
                end else begin
                    w_valid_nxt = 1'b1;
`ifdef KEY_ENC_REPEAT_EN
                    if (w_tick) begin
                        if (r_rpt == RPT_LAST) begin
                            w_press_nxt = 1'b1;
                            w_rpt_nxt   = '0;
                        end else begin
                            w_rpt_nxt   = r_rpt + RPT_ONE;
                        end
                    end else begin
                        w_rpt_nxt = r_rpt;
                    end
`endif
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_code    <= 3'd0;
            r_valid   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_multi   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_code    <= w_code_nxt;
            r_valid   <= w_valid_nxt;
            r_press   <= w_press_nxt;
            r_release <= w_release_nxt;
            r_multi   <= w_multiple;
        end
    end

`ifdef KEY_ENC_REPEAT_EN
    // Auto-repeat tick counter.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rpt <= '0;
        end else begin
            r_rpt <= w_rpt_nxt;
        end
    end
`else
    // The sample tick only drives the auto-repeat counter.
    logic w_unused_tick;
    assign w_unused_tick = w_tick;
`endif

    assign o_code    = r_code;
    assign o_valid   = r_valid;
    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_multi   = r_multi;

endmodule

// File: tb/tb_key_encoder83.sv
// tb_key_encoder83: directed self-checking bench for key_encoder83 (DEBOUNCE_CYCLES=4).
module tb_key_encoder83;

    logic       clk;
    logic       rst;
    logic [7:0] key_n;
    logic [2:0] code;
    logic       valid;
    logic       press;
    logic       rel;
    logic       multi;

    int n_tests;
    int n_fail;
    int press_cnt;
    int rel_cnt;
    logic both_seen;
    logic wide_seen;
    logic prev_press;
    logic db_moved;
    logic valid_seen;

    key_encoder83 #(
        .DEBOUNCE_CYCLES (4)
`ifdef KEY_ENC_REPEAT_EN
        , .REPEAT_TICKS  (3)
`endif
    ) u_dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_key_n   (key_n),
        .o_code    (code),
        .o_valid   (valid),
        .o_press   (press),
        .o_release (rel),
        .o_multi   (multi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Event monitor, sampled 1 time unit after each rising edge.
    always @(posedge clk) begin
        #1;
        if (press) press_cnt++;
        if (rel) rel_cnt++;
        if (press && rel) both_seen = 1'b1;
        if (press && prev_press) wide_seen = 1'b1;
        prev_press = press;
        if (u_dut.u_deb.o_db !== 8'hFF) db_moved = 1'b1;
        if (valid) valid_seen = 1'b1;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clr;
        press_cnt  = 0;
        rel_cnt    = 0;
        db_moved   = 1'b0;
        valid_seen = 1'b0;
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        both_seen = 1'b0; wide_seen = 1'b0; prev_press = 1'b0;
        clr();
        key_n = 8'hFF;
        rst   = 1'b1;
        cyc(3);
        chk("rst_code",    {5'd0, code}, 8'h00);
        chk("rst_valid",   {7'd0, valid}, 8'h00);
        chk("rst_press",   {7'd0, press}, 8'h00);
        chk("rst_release", {7'd0, rel}, 8'h00);
        chk("rst_multi",   {7'd0, multi}, 8'h00);
        rst = 1'b0;
        clr();
        cyc(100);
        chk("idle_press_cnt", 8'(press_cnt), 8'd0);
        chk("idle_rel_cnt",   8'(rel_cnt), 8'd0);
        chk("idle_valid",     {7'd0, valid_seen}, 8'h00);

        // Single key 7 -> code 0
        clr();
        key_n = 8'b0111_1111;
        cyc(14);
        chk("k7_valid", {7'd0, valid}, 8'h01);
        chk("k7_code",  {5'd0, code}, 8'h00);
        chk("k7_press", 8'(press_cnt), 8'd1);
        chk("k7_multi", {7'd0, multi}, 8'h00);
        key_n = 8'hFF;
        cyc(14);
        chk("k7r_valid", {7'd0, valid}, 8'h00);
        chk("k7r_rel",   8'(rel_cnt), 8'd1);
        chk("k7r_code",  {5'd0, code}, 8'h00);
        chk("k7r_press", 8'(press_cnt), 8'd1);

        // Five 1-cycle glitches on key 0, spacing 7
        clr();
        for (int g = 0; g < 5; g++) begin
            key_n = 8'hFE;
            cyc(1);
            key_n = 8'hFF;
            cyc(6);
        end
        cyc(14);
        chk("gl_press",  8'(press_cnt), 8'd0);
        chk("gl_valid",  {7'd0, valid_seen}, 8'h00);
        chk("gl_db",     {7'd0, db_moved}, 8'h00);

        // Keys 5 and 2 together, then release 5
        clr();
        key_n = 8'b1101_1011;
        cyc(14);
        chk("k52_code",  {5'd0, code}, 8'h02);
        chk("k52_multi", {7'd0, multi}, 8'h01);
        chk("k52_press", 8'(press_cnt), 8'd1);
        chk("k52_valid", {7'd0, valid}, 8'h01);
        key_n = 8'b1111_1011;
        cyc(14);
        chk("k2_code",  {5'd0, code}, 8'h05);
        chk("k2_press", 8'(press_cnt), 8'd2);
        chk("k2_rel",   8'(rel_cnt), 8'd0);
        chk("k2_multi", {7'd0, multi}, 8'h00);
        chk("k2_valid", {7'd0, valid}, 8'h01);
        key_n = 8'hFF;
        cyc(14);
        chk("k2r_rel", 8'(rel_cnt), 8'd1);

        // Reset in the middle of a key 0 hold
        clr();
        key_n = 8'hFE;
        cyc(14);
        chk("k0_code",  {5'd0, code}, 8'h07);
        chk("k0_valid", {7'd0, valid}, 8'h01);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", {7'd0, valid}, 8'h00);
        chk("mid_rst_code",  {5'd0, code}, 8'h00);
        cyc(2);
        rst = 1'b0;
        clr();
        cyc(14);
        chk("post_rst_press", 8'(press_cnt), 8'd1);
        chk("post_rst_code",  {5'd0, code}, 8'h07);
        chk("post_rst_valid", {7'd0, valid}, 8'h01);
        key_n = 8'hFF;
        cyc(14);

        // Key 3 held 40 cycles
        clr();
        key_n = 8'hF7;
        cyc(40);
        chk("k3_code", {5'd0, code}, 8'h04);
`ifdef KEY_ENC_REPEAT_EN
        chk("k3_repeat", {7'd0, (press_cnt >= 3)}, 8'h01);
`else
        chk("k3_single", 8'(press_cnt), 8'd1);
`endif
        key_n = 8'hFF;
        cyc(14);

        chk("press_rel_overlap", {7'd0, both_seen}, 8'h00);
        chk("press_width",       {7'd0, wide_seen}, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
